// File: rtl/mcu_spi_slave.sv
// -----------------------------------------------------------------------------
// mcu_spi_slave
//   SPI mode-0 slave front end for the MCU command interface. The SPI pins are
//   oversampled in the clk domain. The first byte of each SSEL frame is
//   presented as a command and every later byte as a parameter. The reply byte
//   supplied on input_data is shifted out on MISO, MSB first.
//
// Ports
//   clk, rst_n         system clock, asynchronous active-low reset
//   SCK, MOSI, SSEL    raw SPI pins (asynchronous to clk; SSEL active low)
//   MISO, miso_oe      serial reply data and pad output enable
//   input_data         reply byte, loaded at the start of each byte slot
//   cmd_ready          1-clk pulse: command byte (byte 1 of frame) complete
//   param_ready        1-clk pulse: parameter byte (byte >= 2) complete
//   cmd_data           last command byte received
//   param_data         last parameter byte received
//   byte_cnt           completed bytes in the current frame (saturating)
//   bit_cnt            bits received in the current byte
//   startmessage       1-clk pulse when SSEL is asserted
//   endmessage         1-clk pulse when SSEL is released
// -----------------------------------------------------------------------------
module mcu_spi_slave #(
  parameter int SYNC_STAGES = 3,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             SCK,
  input  logic             MOSI,
  input  logic             SSEL,
  output logic             MISO,
  output logic             miso_oe,
  input  logic [7:0]       input_data,
  output logic             cmd_ready,
  output logic             param_ready,
  output logic [7:0]       cmd_data,
  output logic [7:0]       param_data,
  output logic [CNT_W-1:0] byte_cnt,
  output logic [2:0]       bit_cnt,
  output logic             startmessage,
  output logic             endmessage
);

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES-1:0] ssel_sync;

  logic [7:0] rx_shift;
  logic [7:0] tx_shift;

  logic sck_rise;
  logic sck_fall;
  logic ssel_rise;
  logic ssel_fall;
  logic ssel_act;
  logic mosi_s;
  logic [7:0] rx_byte;

  // Pin synchronisers; reset to the idle bus state so that releasing reset
  // never manufactures an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync  <= '0;
      mosi_sync <= '0;
      ssel_sync <= '1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SCK};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      ssel_sync <= {ssel_sync[SYNC_STAGES-2:0], SSEL};
    end
  end

  // Edges are taken between the two oldest synchroniser stages.
  assign sck_rise  = ~sck_sync[SYNC_STAGES-1]  &  sck_sync[SYNC_STAGES-2];
  assign sck_fall  =  sck_sync[SYNC_STAGES-1]  & ~sck_sync[SYNC_STAGES-2];
  assign ssel_rise = ~ssel_sync[SYNC_STAGES-1] &  ssel_sync[SYNC_STAGES-2];
  assign ssel_fall =  ssel_sync[SYNC_STAGES-1] & ~ssel_sync[SYNC_STAGES-2];
  assign ssel_act  = ~ssel_sync[SYNC_STAGES-1];
  assign mosi_s    =  mosi_sync[SYNC_STAGES-2];
  assign rx_byte   = {rx_shift[6:0], mosi_s};

  assign MISO    = tx_shift[7];
  assign miso_oe = ssel_act;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_shift     <= '0;
      tx_shift     <= '0;
      cmd_ready    <= 1'b0;
      param_ready  <= 1'b0;
      cmd_data     <= '0;
      param_data   <= '0;
      byte_cnt     <= '0;
      bit_cnt      <= '0;
      startmessage <= 1'b0;
      endmessage   <= 1'b0;
    end else begin
      cmd_ready    <= 1'b0;
      param_ready  <= 1'b0;
      startmessage <= 1'b0;
      endmessage   <= 1'b0;

      if (ssel_rise) begin
        // End of frame wins over any coincident SCK edge; a partial byte is
        // simply dropped by clearing the bit position.
        endmessage <= 1'b1;
        bit_cnt    <= '0;
      end else if (ssel_fall) begin
        // Command byte returns whatever tx holds now, so clear it here.
        startmessage <= 1'b1;
        byte_cnt     <= '0;
        bit_cnt      <= '0;
        rx_shift     <= '0;
        tx_shift     <= '0;
      end else if (ssel_act) begin
        if (sck_rise) begin
          rx_shift <= rx_byte;
          bit_cnt  <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            if (byte_cnt != {CNT_W{1'b1}}) byte_cnt <= byte_cnt + CNT_W'(1);
            if (byte_cnt == '0) begin
              cmd_data  <= rx_byte;
              cmd_ready <= 1'b1;
            end else begin
              param_data  <= rx_byte;
              param_ready <= 1'b1;
            end
          end
        end else if (sck_fall) begin
          // bit_cnt == 0 on a falling edge means a new byte slot is starting.
          if (bit_cnt == 3'd0) tx_shift <= input_data;
          else                 tx_shift <= {tx_shift[6:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_mcu_spi_slave.sv
module tb_mcu_spi_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        SCK = 1'b0;
  logic        MOSI = 1'b0;
  logic        SSEL = 1'b1;
  logic        MISO;
  logic        miso_oe;
  logic [7:0]  input_data = 8'h00;
  logic        cmd_ready;
  logic        param_ready;
  logic [7:0]  cmd_data;
  logic [7:0]  param_data;
  logic [31:0] byte_cnt;
  logic [2:0]  bit_cnt;
  logic        startmessage;
  logic        endmessage;

  mcu_spi_slave #(.SYNC_STAGES(3), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .SCK(SCK), .MOSI(MOSI), .SSEL(SSEL),
    .MISO(MISO), .miso_oe(miso_oe), .input_data(input_data),
    .cmd_ready(cmd_ready), .param_ready(param_ready),
    .cmd_data(cmd_data), .param_data(param_data),
    .byte_cnt(byte_cnt), .bit_cnt(bit_cnt),
    .startmessage(startmessage), .endmessage(endmessage)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Pulse monitor (samples on the falling clk edge).
  int          n_cmd, n_param, n_both, n_start, n_end;
  logic [7:0]  last_cmd;
  logic [31:0] cmd_bc;
  logic [7:0]  plog [0:299];
  logic [31:0] pbc  [0:299];
  logic [7:0]  tx_reply = 8'h00;

  always @(negedge clk) begin
    if (cmd_ready) begin
      n_cmd++;
      last_cmd = cmd_data;
      cmd_bc = byte_cnt;
      input_data = tx_reply;
    end
    if (param_ready) begin
      if (n_param < 300) begin
        plog[n_param] = param_data;
        pbc[n_param]  = byte_cnt;
      end
      n_param++;
      input_data = tx_reply;
    end
    if (cmd_ready && param_ready) n_both++;
    if (startmessage) n_start++;
    if (endmessage) n_end++;
  end

  logic [7:0] tx_bytes [0:299];
  logic [7:0] rx_bytes [0:299];
  logic       oe_seen;

  task automatic clear_counts();
    @(posedge clk);
    n_cmd = 0; n_param = 0; n_both = 0; n_start = 0; n_end = 0;
    last_cmd = 8'h00; cmd_bc = 32'h0;
    @(negedge clk);
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Shift the top nbits of b, MSB first; SCK half period = 4 clk.
  task automatic spi_byte(input logic [7:0] b, input int nbits, output logic [7:0] r);
    r = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      MOSI = b[i];
      wait_n(4);
      r[i] = MISO;
      SCK = 1'b1;
      wait_n(4);
      SCK = 1'b0;
    end
  endtask

  // Frame of nbytes from tx_bytes; the last byte carries last_bits bits.
  task automatic spi_frame(input int nbytes, input int last_bits);
    logic [7:0] r;
    SSEL = 1'b0;
    wait_n(4);
    oe_seen = miso_oe;
    for (int k = 0; k < nbytes; k++) begin
      spi_byte(tx_bytes[k], (k == nbytes - 1) ? last_bits : 8, r);
      rx_bytes[k] = r;
    end
    wait_n(4);
    SSEL = 1'b1;
    wait_n(8);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wait_n(3);
    total++; if (cmd_data !== 8'h00) $display("FAIL reset_cmd_data got %h exp 00", cmd_data); else passed++;
    total++; if (byte_cnt !== 32'h0 || bit_cnt !== 3'd0) $display("FAIL reset_cnts got %0d/%0d exp 0/0", byte_cnt, bit_cnt); else passed++;
    total++; if ({MISO, miso_oe, cmd_ready, param_ready, startmessage, endmessage} !== 6'b0) $display("FAIL reset_bits got %b exp 000000", {MISO, miso_oe, cmd_ready, param_ready, startmessage, endmessage}); else passed++;
    rst_n = 1'b1;
    clear_counts();
    wait_n(10);
    total++; if (n_start !== 0) $display("FAIL reset_no_start got %0d exp 0", n_start); else passed++;
  endtask

  task automatic test_frame();
    clear_counts();
    tx_bytes[0] = 8'h1A; tx_bytes[1] = 8'h12; tx_bytes[2] = 8'h34; tx_bytes[3] = 8'h56;
    spi_frame(4, 8);
    total++; if (oe_seen !== 1'b1) $display("FAIL t1_oe got %b exp 1", oe_seen); else passed++;
    total++; if (n_start !== 1) $display("FAIL t1_start got %0d exp 1", n_start); else passed++;
    total++; if (n_cmd !== 1) $display("FAIL t1_ncmd got %0d exp 1", n_cmd); else passed++;
    total++; if (last_cmd !== 8'h1A || cmd_bc !== 32'd1) $display("FAIL t1_cmd got %h/%0d exp 1a/1", last_cmd, cmd_bc); else passed++;
    total++; if (n_param !== 3) $display("FAIL t1_nparam got %0d exp 3", n_param); else passed++;
    total++; if (plog[0] !== 8'h12 || pbc[0] !== 32'd2) $display("FAIL t1_p0 got %h/%0d exp 12/2", plog[0], pbc[0]); else passed++;
    total++; if (plog[1] !== 8'h34 || pbc[1] !== 32'd3) $display("FAIL t1_p1 got %h/%0d exp 34/3", plog[1], pbc[1]); else passed++;
    total++; if (plog[2] !== 8'h56 || pbc[2] !== 32'd4) $display("FAIL t1_p2 got %h/%0d exp 56/4", plog[2], pbc[2]); else passed++;
    total++; if (n_end !== 1) $display("FAIL t1_end got %0d exp 1", n_end); else passed++;
    total++; if (n_both !== 0) $display("FAIL t1_both got %0d exp 0", n_both); else passed++;
    total++; if (byte_cnt !== 32'd4 || cmd_data !== 8'h1A || param_data !== 8'h56) $display("FAIL t1_held got %0d/%h/%h exp 4/1a/56", byte_cnt, cmd_data, param_data); else passed++;
    total++; if (miso_oe !== 1'b0) $display("FAIL t1_oe_off got %b exp 0", miso_oe); else passed++;
  endtask

  task automatic test_miso();
    clear_counts();
    tx_reply = 8'hA5;
    tx_bytes[0] = 8'hF0; tx_bytes[1] = 8'h00;
    spi_frame(2, 8);
    tx_reply = 8'h00;
    total++; if (rx_bytes[0] !== 8'h00) $display("FAIL t2_miso_b1 got %h exp 00", rx_bytes[0]); else passed++;
    total++; if (rx_bytes[1] !== 8'hA5) $display("FAIL t2_miso_b2 got %h exp a5", rx_bytes[1]); else passed++;
    total++; if (last_cmd !== 8'hF0 || param_data !== 8'h00) $display("FAIL t2_rx got %h/%h exp f0/00", last_cmd, param_data); else passed++;
  endtask

  task automatic test_partial();
    clear_counts();
    tx_bytes[0] = 8'h3C; tx_bytes[1] = 8'hC3;
    spi_frame(2, 5);
    total++; if (n_param !== 0) $display("FAIL t3_no_param got %0d exp 0", n_param); else passed++;
    total++; if (n_cmd !== 1 || n_end !== 1) $display("FAIL t3_cmd_end got %0d/%0d exp 1/1", n_cmd, n_end); else passed++;
    total++; if (bit_cnt !== 3'd0 || byte_cnt !== 32'd1) $display("FAIL t3_cnts got %0d/%0d exp 0/1", bit_cnt, byte_cnt); else passed++;
    clear_counts();
    tx_bytes[0] = 8'h77;
    spi_frame(1, 8);
    total++; if (n_cmd !== 1 || last_cmd !== 8'h77 || cmd_bc !== 32'd1) $display("FAIL t3_next got %0d/%h/%0d exp 1/77/1", n_cmd, last_cmd, cmd_bc); else passed++;
    total++; if (param_data !== 8'h00) $display("FAIL t3_param_held got %h exp 00", param_data); else passed++;
  endtask

  task automatic test_idle_sck();
    clear_counts();
    for (int i = 0; i < 16; i++) begin
      MOSI = i[0];
      wait_n(4);
      SCK = ~SCK;
    end
    wait_n(8);
    total++; if (n_cmd + n_param + n_start + n_end !== 0) $display("FAIL t4_pulses got %0d exp 0", n_cmd + n_param + n_start + n_end); else passed++;
    total++; if (byte_cnt !== 32'd1 || bit_cnt !== 3'd0) $display("FAIL t4_cnts got %0d/%0d exp 1/0", byte_cnt, bit_cnt); else passed++;
    total++; if (miso_oe !== 1'b0) $display("FAIL t4_oe got %b exp 0", miso_oe); else passed++;
  endtask

  task automatic test_reset_midframe();
    logic [7:0] r;
    clear_counts();
    SSEL = 1'b0;
    wait_n(4);
    spi_byte(8'h91, 3, r);
    wait_n(2);
    total++; if (bit_cnt !== 3'd3) $display("FAIL t5_bits got %0d exp 3", bit_cnt); else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++; if (cmd_data !== 8'h00 || param_data !== 8'h00) $display("FAIL t5_async_data got %h/%h exp 00/00", cmd_data, param_data); else passed++;
    total++; if (byte_cnt !== 32'h0 || bit_cnt !== 3'd0 || miso_oe !== 1'b0) $display("FAIL t5_async_ctl got %0d/%0d/%b exp 0/0/0", byte_cnt, bit_cnt, miso_oe); else passed++;
    SSEL = 1'b1;
    wait_n(3);
    rst_n = 1'b1;
    clear_counts();
    wait_n(4);
    tx_bytes[0] = 8'h91; tx_bytes[1] = 8'hFF;
    spi_frame(2, 8);
    total++; if (n_cmd !== 1 || last_cmd !== 8'h91) $display("FAIL t5_cmd got %0d/%h exp 1/91", n_cmd, last_cmd); else passed++;
    total++; if (n_param !== 1 || plog[0] !== 8'hFF || pbc[0] !== 32'd2) $display("FAIL t5_param got %0d/%h/%0d exp 1/ff/2", n_param, plog[0], pbc[0]); else passed++;
  endtask

  task automatic test_back_to_back();
    int bad;
    clear_counts();
    tx_bytes[0] = 8'h5A;
    for (int i = 1; i <= 256; i++) tx_bytes[i] = 8'(i * 7 + 3);
    spi_frame(257, 8);
    total++; if (n_param !== 256) $display("FAIL t6_nparam got %0d exp 256", n_param); else passed++;
    total++; if (byte_cnt !== 32'd257) $display("FAIL t6_byte_cnt got %0d exp 257", byte_cnt); else passed++;
    bad = 0;
    for (int i = 0; i < 256; i++)
      if (plog[i] !== 8'((i + 1) * 7 + 3) || pbc[i] !== 32'(i + 2)) bad++;
    total++; if (bad !== 0) $display("FAIL t6_seq got %0d bad entries exp 0", bad); else passed++;
    total++; if (n_cmd !== 1 || n_both !== 0) $display("FAIL t6_cmd got %0d/%0d exp 1/0", n_cmd, n_both); else passed++;
  endtask

  initial begin
    n_cmd = 0; n_param = 0; n_both = 0; n_start = 0; n_end = 0;
    test_reset();
    test_frame();
    test_miso();
    test_partial();
    test_idle_sck();
    test_reset_midframe();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
